// File: rtl/spi_pkg.sv
// Shared definitions for the two-client SPI transaction arbiter.
package spi_pkg;

  localparam int MAX_BYTES_PER_CS_DEF = 10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT   = 3'd1,
    SEND    = 3'd2,
    WAIT_RX = 3'd3,
    FINISH  = 3'd4
  } state_e;

endpackage

// File: rtl/spi_rr_arb2.sv
// Two-way round-robin selector: the client after the last owner wins a tie.
module spi_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (last_i) begin
      if (req_i[0])      gnt_o = 2'b01;
      else if (req_i[1]) gnt_o = 2'b10;
    end else begin
      if (req_i[1])      gnt_o = 2'b10;
      else if (req_i[0]) gnt_o = 2'b01;
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Arbitrates two clients onto one SPI master, one chip-select frame at a time,
// with length checking and a per-byte receive timeout.
module spi_txn_arbiter
  import spi_pkg::*;
#(
  parameter int MAX_BYTES_PER_CS = MAX_BYTES_PER_CS_DEF,
  parameter int RX_TIMEOUT_CLKS  = 1024,
  localparam int CW = $clog2(MAX_BYTES_PER_CS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    i_Req,
  input  logic [CW-1:0] i_Len0,
  input  logic [CW-1:0] i_Len1,
  input  logic [7:0]    i_TX_Byte0,
  input  logic [7:0]    i_TX_Byte1,
  input  logic [1:0]    i_TX_Valid,
  output logic [1:0]    o_TX_Ack,
  output logic [7:0]    o_RX_Byte,
  output logic [1:0]    o_RX_Valid,
  output logic [1:0]    o_Done,
  output logic [1:0]    o_Err,
  output logic [1:0]    o_Grant,
  output logic [7:0]    o_M_TX_Byte,
  output logic          o_M_TX_En,
  input  logic          i_M_TX_Ready,
  output logic [CW-1:0] o_M_TX_Count,
  input  logic [7:0]    i_M_RX_Byte,
  input  logic          i_M_RX_En
);

  localparam int            TW       = $clog2(RX_TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] MAX_LEN  = CW'(MAX_BYTES_PER_CS);
  localparam logic [TW-1:0] TMO_LAST = TW'(RX_TIMEOUT_CLKS - 1);

  state_e        state_q, state_d;
  logic          owner_q, owner_d, last_q, last_d, err_flag_q, err_flag_d;
  logic [1:0]    grant_q, grant_d, rxv_q, rxv_d, done_q, done_d, err_q, err_d;
  logic [CW-1:0] len_q, len_d, tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic [1:0]    arb_gnt;
  logic [CW-1:0] sel_len, rx_cnt_inc;
  logic [7:0]    own_byte;
  logic          fire;

  spi_rr_arb2 u_arb (
    .req_i  (i_Req),
    .last_i (last_q),
    .gnt_o  (arb_gnt)
  );

  assign sel_len    = owner_q ? i_Len1 : i_Len0;
  assign own_byte   = owner_q ? i_TX_Byte1 : i_TX_Byte0;
  assign rx_cnt_inc = rx_cnt_q + CW'(1);
  // The count guard keeps a stray extra strobe from ever overrunning the frame.
  assign fire = (state_q == SEND) && i_TX_Valid[owner_q] && i_M_TX_Ready &&
                (tx_cnt_q < len_q);

  assign o_Grant      = grant_q;
  assign o_M_TX_Count = len_q;
  assign o_M_TX_En    = fire;
  assign o_M_TX_Byte  = fire ? own_byte : 8'h00;
  assign o_TX_Ack     = fire ? grant_q : 2'b00;
  assign o_RX_Byte    = rx_byte_q;
  assign o_RX_Valid   = rxv_q;
  assign o_Done       = done_q;
  assign o_Err        = err_q;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    err_flag_d = err_flag_q;
    grant_d    = grant_q;
    len_d      = len_q;
    tx_cnt_d   = tx_cnt_q;
    rx_cnt_d   = rx_cnt_q;
    tmo_d      = tmo_q;
    rx_byte_d  = rx_byte_q;
    rxv_d      = 2'b00;
    done_d     = 2'b00;
    err_d      = 2'b00;
    case (state_q)
      IDLE: begin
        if (|i_Req) begin
          grant_d = arb_gnt;
          owner_d = arb_gnt[1];
          state_d = GRANT;
        end
      end
      GRANT: begin
        len_d      = sel_len;
        tx_cnt_d   = '0;
        rx_cnt_d   = '0;
        tmo_d      = '0;
        err_flag_d = 1'b0;
        if ((sel_len == '0) || (sel_len > MAX_LEN)) begin
          err_flag_d = 1'b1;
          state_d    = FINISH;
        end else begin
          state_d    = SEND;
        end
      end
      SEND: begin
        if (fire) begin
          tx_cnt_d = tx_cnt_q + CW'(1);
          tmo_d    = '0;
          state_d  = WAIT_RX;
        end
      end
      WAIT_RX: begin
        if (i_M_RX_En) begin
          rx_byte_d = i_M_RX_Byte;
          rxv_d     = grant_q;
          rx_cnt_d  = rx_cnt_inc;
          state_d   = (rx_cnt_inc == len_q) ? FINISH : SEND;
        end else if (tmo_q == TMO_LAST) begin
          err_flag_d = 1'b1;
          state_d    = FINISH;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      FINISH: begin
        done_d  = err_flag_q ? 2'b00 : grant_q;
        err_d   = err_flag_q ? grant_q : 2'b00;
        last_d  = owner_q;
        grant_d = 2'b00;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // last_q resets to 1 so that client 0 is favoured first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      err_flag_q <= 1'b0;
      grant_q    <= 2'b00;
      len_q      <= '0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      tmo_q      <= '0;
      rx_byte_q  <= 8'h00;
      rxv_q      <= 2'b00;
      done_q     <= 2'b00;
      err_q      <= 2'b00;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      err_flag_q <= err_flag_d;
      grant_q    <= grant_d;
      len_q      <= len_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      tmo_q      <= tmo_d;
      rx_byte_q  <= rx_byte_d;
      rxv_q      <= rxv_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Bench for spi_txn_arbiter: client sources, a loopback SPI master model and
// a transaction-level scoreboard of expected strobes, bytes and completions.
module tb_spi_txn_arbiter;

  localparam int MAXB = 10;
  localparam int TMO  = 64;
  localparam int CW   = $clog2(MAXB + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    i_Req, i_TX_Valid, o_TX_Ack, o_RX_Valid, o_Done, o_Err, o_Grant;
  logic [CW-1:0] i_Len0, i_Len1, o_M_TX_Count;
  logic [7:0]    i_TX_Byte0, i_TX_Byte1, o_RX_Byte, o_M_TX_Byte, i_M_RX_Byte;
  logic          o_M_TX_En, i_M_TX_Ready, i_M_RX_En;

  always #5 clk = ~clk;

  spi_txn_arbiter #(.MAX_BYTES_PER_CS(MAXB), .RX_TIMEOUT_CLKS(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .i_Req(i_Req), .i_Len0(i_Len0), .i_Len1(i_Len1),
    .i_TX_Byte0(i_TX_Byte0), .i_TX_Byte1(i_TX_Byte1), .i_TX_Valid(i_TX_Valid),
    .o_TX_Ack(o_TX_Ack), .o_RX_Byte(o_RX_Byte), .o_RX_Valid(o_RX_Valid),
    .o_Done(o_Done), .o_Err(o_Err), .o_Grant(o_Grant), .o_M_TX_Byte(o_M_TX_Byte),
    .o_M_TX_En(o_M_TX_En), .i_M_TX_Ready(i_M_TX_Ready), .o_M_TX_Count(o_M_TX_Count),
    .i_M_RX_Byte(i_M_RX_Byte), .i_M_RX_En(i_M_RX_En)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int viol  = 0;
  int req_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] cd [2][16];
  int cn [2];
  int cidx [2];
  bit cadv [2];
  int hold_at [2];
  int hold_left [2];

  bit         m_busy;
  logic [7:0] m_byte;
  int         m_cnt;
  int         m_lat = 2;
  bit         m_rand = 1'b0;
  bit         m_spur = 1'b0;
  int         m_drop_at = -1;
  int         m_en_n = 0;

  logic [7:0]    en_byte[$], x_byte[$], rx_b[$], x_rxb[$];
  logic [1:0]    en_gnt[$], x_gnt[$], rx_v[$], x_rxv[$], dn_v[$], x_dn[$], er_v[$], x_er[$];
  logic [CW-1:0] en_cnt[$], x_cnt[$];
  int            en_cyc[$], er_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Environment: drive inputs just after the falling edge, sample outputs once settled.
  initial begin
    logic       en_s, vc;
    logic [7:0] byte_s, bc;
    logic [1:0] ack_s;
    i_M_TX_Ready = 1'b1; i_M_RX_En = 1'b0; i_M_RX_Byte = 8'h00;
    i_TX_Valid = 2'b00; i_TX_Byte0 = 8'h00; i_TX_Byte1 = 8'h00;
    forever begin
      @(negedge clk);
      i_M_RX_En = 1'b0;
      if (!rst_n) begin
        m_busy = 1'b0;
        i_M_TX_Ready = 1'b1;
      end else if (m_busy) begin
        i_M_TX_Ready = 1'b0;
        if (m_cnt == 0) begin
          m_busy = 1'b0;
          i_M_TX_Ready = 1'b1;
          if (m_en_n - 1 != m_drop_at) begin
            i_M_RX_En = 1'b1;
            i_M_RX_Byte = m_byte;
          end
        end else begin
          m_cnt--;
        end
      end else if (m_spur && $urandom_range(0, 3) == 0) begin
        i_M_RX_En = 1'b1;
        i_M_RX_Byte = 8'($urandom);
      end
      for (int c = 0; c < 2; c++) begin
        if (cadv[c]) cidx[c]++;
        cadv[c] = 1'b0;
        if (hold_left[c] > 0 && cidx[c] == hold_at[c]) begin
          vc = 1'b0;
          hold_left[c]--;
        end else begin
          vc = (cidx[c] < cn[c]);
        end
        bc = cd[c][cidx[c] & 15];
        if (c == 0) begin i_TX_Valid[0] = vc; i_TX_Byte0 = bc; end
        else        begin i_TX_Valid[1] = vc; i_TX_Byte1 = bc; end
      end
      #1;
      en_s = o_M_TX_En; byte_s = o_M_TX_Byte; ack_s = o_TX_Ack;
      if (en_s) begin
        en_byte.push_back(byte_s); en_gnt.push_back(o_Grant);
        en_cnt.push_back(o_M_TX_Count); en_cyc.push_back(cyc);
        if (!$onehot(o_Grant)) viol++;
      end
      if (|o_RX_Valid) begin rx_b.push_back(o_RX_Byte); rx_v.push_back(o_RX_Valid); end
      if (|o_Done) dn_v.push_back(o_Done);
      if (|o_Err) begin er_v.push_back(o_Err); er_cyc.push_back(cyc); end
      if ((ack_s & ~o_Grant) != 2'b00) viol++;
      if ((o_RX_Valid & ~o_Grant) != 2'b00) viol++;
      if ((o_Done & o_Err) != 2'b00) viol++;
      for (int c = 0; c < 2; c++) cadv[c] = ack_s[c];
      if (en_s && rst_n && !m_busy) begin
        m_busy = 1'b1;
        m_byte = byte_s;
        m_cnt  = m_rand ? $urandom_range(1, 3) : m_lat;
        m_en_n++;
      end
    end
  end

  task automatic clear_logs();
    en_byte.delete(); en_gnt.delete(); en_cnt.delete(); en_cyc.delete();
    rx_b.delete(); rx_v.delete(); dn_v.delete(); er_v.delete(); er_cyc.delete();
    x_byte.delete(); x_gnt.delete(); x_cnt.delete(); x_rxb.delete(); x_rxv.delete();
    x_dn.delete(); x_er.delete();
    m_en_n = 0;
  endtask

  task automatic load_client(input int c, input int len);
    for (int i = 0; i < 16; i++) cd[c][i] = 8'($urandom);
    cn[c] = len; cidx[c] = 0; cadv[c] = 1'b0; hold_left[c] = 0; hold_at[c] = 0;
  endtask

  // Reference: a legal frame moves every client byte out and back on the owner;
  // an illegal length produces only an error to that client.
  task automatic add_txn(input int c, input int len);
    logic [1:0] oh;
    oh = (c == 0) ? 2'b01 : 2'b10;
    if (len == 0 || len > MAXB) begin
      x_er.push_back(oh);
    end else begin
      for (int i = 0; i < len; i++) begin
        x_byte.push_back(cd[c][i]); x_gnt.push_back(oh); x_cnt.push_back(CW'(len));
        x_rxb.push_back(cd[c][i]);  x_rxv.push_back(oh);
      end
      x_dn.push_back(oh);
    end
  endtask

  task automatic wait_grant(input logic [1:0] g, input string tag);
    int n;
    n = 0;
    while (o_Grant !== g && n < 3000) begin @(negedge clk); n++; end
    chk({tag, "_grant"}, o_Grant, g);
  endtask

  task automatic wait_events(input int n, input string tag);
    int k;
    k = 0;
    while ((dn_v.size() + er_v.size()) < n && k < 3000) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    chk({tag, "_ends"}, dn_v.size() + er_v.size(), n);
  endtask

  task automatic run_one(input int c, input int len, input string tag);
    if (c == 0) i_Len0 = CW'(len); else i_Len1 = CW'(len);
    req_cyc = cyc;
    i_Req[c] = 1'b1;
    wait_grant((c == 0) ? 2'b01 : 2'b10, tag);
    i_Req[c] = 1'b0;
    wait_events(1, tag);
  endtask

  task automatic compare_logs(input string tag);
    chk({tag, "_n_en"}, en_byte.size(), x_byte.size());
    for (int i = 0; i < en_byte.size() && i < x_byte.size(); i++) begin
      chk($sformatf("%s_en%0d_byte", tag, i), en_byte[i], x_byte[i]);
      chk($sformatf("%s_en%0d_gnt", tag, i), en_gnt[i], x_gnt[i]);
      chk($sformatf("%s_en%0d_cnt", tag, i), en_cnt[i], x_cnt[i]);
    end
    chk({tag, "_n_rx"}, rx_b.size(), x_rxb.size());
    for (int i = 0; i < rx_b.size() && i < x_rxb.size(); i++) begin
      chk($sformatf("%s_rx%0d_byte", tag, i), rx_b[i], x_rxb[i]);
      chk($sformatf("%s_rx%0d_vld", tag, i), rx_v[i], x_rxv[i]);
    end
    chk({tag, "_n_done"}, dn_v.size(), x_dn.size());
    for (int i = 0; i < dn_v.size() && i < x_dn.size(); i++)
      chk($sformatf("%s_done%0d", tag, i), dn_v[i], x_dn[i]);
    chk({tag, "_n_err"}, er_v.size(), x_er.size());
    for (int i = 0; i < er_v.size() && i < x_er.size(); i++)
      chk($sformatf("%s_err%0d", tag, i), er_v[i], x_er[i]);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_grant"}, o_Grant, 0);
    chk({tag, "_count"}, o_M_TX_Count, 0);
    chk({tag, "_mbyte"}, o_M_TX_Byte, 0);
    chk({tag, "_men"}, o_M_TX_En, 0);
    chk({tag, "_rxbyte"}, o_RX_Byte, 0);
    chk({tag, "_rxv"}, o_RX_Valid, 0);
    chk({tag, "_done"}, o_Done, 0);
    chk({tag, "_err"}, o_Err, 0);
    chk({tag, "_ack"}, o_TX_Ack, 0);
  endtask

  initial begin
    int badl [2];
    int c, len, r, k;
    rst_n = 1'b0; i_Req = 2'b00; i_Len0 = '0; i_Len1 = '0;
    for (int i = 0; i < 2; i++) begin
      cn[i] = 0; cidx[i] = 0; cadv[i] = 1'b0; hold_left[i] = 0; hold_at[i] = 0;
    end
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Both clients request from reset: client 0 then client 1.
    clear_logs();
    load_client(0, 2); load_client(1, 2);
    add_txn(0, 2); add_txn(1, 2);
    i_Len0 = CW'(2); i_Len1 = CW'(2);
    req_cyc = cyc;
    i_Req = 2'b11;
    wait_grant(2'b01, "both0");
    i_Req[0] = 1'b0;
    wait_grant(2'b10, "both1");
    i_Req[1] = 1'b0;
    wait_events(2, "both");
    compare_logs("both");
    chk("both_first_en_latency", (en_cyc.size() > 0) ? en_cyc[0] - req_cyc : -1, 2);

    // Client 0, three known bytes.
    clear_logs();
    load_client(0, 3);
    cd[0][0] = 8'h01; cd[0][1] = 8'h02; cd[0][2] = 8'h03;
    add_txn(0, 3);
    run_one(0, 3, "c0len3");
    compare_logs("c0len3");
    chk("c0len3_grant_idle", o_Grant, 0);
    chk("c0len3_en_latency", (en_cyc.size() > 0) ? en_cyc[0] - req_cyc : -1, 2);

    // Illegal lengths from client 1.
    badl[0] = 0; badl[1] = MAXB + 1;
    for (int i = 0; i < 2; i++) begin
      clear_logs();
      load_client(1, badl[i]);
      add_txn(1, badl[i]);
      run_one(1, badl[i], $sformatf("badlen%0d", badl[i]));
      compare_logs($sformatf("badlen%0d", badl[i]));
      chk($sformatf("badlen%0d_err_latency", badl[i]),
          (er_cyc.size() > 0) ? er_cyc[0] - req_cyc : -1, 3);
    end

    // Client 0 withholds its second byte for 20 clocks.
    m_rand = 1'b0; m_lat = 2;
    clear_logs();
    load_client(0, 4);
    hold_at[0] = 1; hold_left[0] = 20;
    add_txn(0, 4);
    run_one(0, 4, "hold");
    compare_logs("hold");
    chk("hold_gap", (en_cyc.size() > 1) ? en_cyc[1] - en_cyc[0] : -1, 21);

    // Randomised frames with random master latency and stray RX strobes.
    m_rand = 1'b1; m_spur = 1'b1;
    for (int t = 0; t < 8; t++) begin
      c = $urandom_range(0, 1);
      r = $urandom_range(0, 7);
      if (r == 0) len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAXB + 1, 15);
      else        len = $urandom_range(1, MAXB);
      clear_logs();
      load_client(c, len);
      add_txn(c, len);
      run_one(c, len, $sformatf("rnd%0d", t));
      compare_logs($sformatf("rnd%0d", t));
    end
    m_spur = 1'b0; m_rand = 1'b0;

    // Master drops the second receive strobe.
    m_lat = 2;
    clear_logs();
    load_client(0, 3);
    m_drop_at = 1;
    for (int i = 0; i < 2; i++) begin
      x_byte.push_back(cd[0][i]); x_gnt.push_back(2'b01); x_cnt.push_back(CW'(3));
    end
    x_rxb.push_back(cd[0][0]); x_rxv.push_back(2'b01);
    x_er.push_back(2'b01);
    run_one(0, 3, "tmo");
    compare_logs("tmo");
    chk("tmo_latency", (en_cyc.size() > 1 && er_cyc.size() > 0) ? er_cyc[0] - en_cyc[1] : -1,
        TMO + 2);
    m_drop_at = -1;

    // Reset in the middle of a 10-byte frame.
    m_lat = 3;
    clear_logs();
    load_client(0, 10);
    i_Len0 = CW'(10);
    i_Req[0] = 1'b1;
    wait_grant(2'b01, "rstmid");
    i_Req[0] = 1'b0;
    k = 0;
    while (en_byte.size() < 4 && k < 500) begin @(negedge clk); k++; end
    chk("rstmid_reached", en_byte.size(), 4);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("rstmid");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rstmid_no_done", dn_v.size(), 0);
    chk("rstmid_no_err", er_v.size(), 0);

    // After reset, a tie goes to client 0 again.
    clear_logs();
    load_client(0, 1); load_client(1, 1);
    add_txn(0, 1); add_txn(1, 1);
    i_Len0 = CW'(1); i_Len1 = CW'(1);
    i_Req = 2'b11;
    wait_grant(2'b01, "post0");
    i_Req[0] = 1'b0;
    wait_grant(2'b10, "post1");
    i_Req[1] = 1'b0;
    wait_events(2, "post");
    compare_logs("post");

    chk("protocol_violations", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
